bus_cycle_ctrl: RTL and testbench

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

---
 rtl/bus_cycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: tracks one CPU bus cycle from address strobe to
// acknowledge. It enables the memory mapper, waits out the mapper register
// latency, classifies the chip selects, then inserts fixed wait states or
// waits for device ready before issuing dtack. Unmapped, ambiguous or
// unanswered cycles end in berr instead.
module bus_cycle_ctrl #(
    parameter int unsigned RAM_WAIT = 2,   // wait clocks for csram1/csram2 (0..15)
    parameter int unsigned ROM_WAIT = 4,   // wait clocks for csrom (0..15)
    parameter int unsigned REG_WAIT = 1,   // wait clocks for csctrl/cspgtbl (0..15)
    parameter int unsigned TIMEOUT  = 64   // ready / chip-select timeout (2..255)
) (
    input  logic clk,
    input  logic reset,
    input  logic cycle_req,
    input  logic csunmap,
    input  logic csram1,
    input  logic csram2,
    input  logic csrom,
    input  logic csio,
    input  logic csgfx,
    input  logic csctrl,
    input  logic cspgtbl,
    input  logic dev_ready,
    output logic map_enable,
    output logic dtack,
    output logic berr,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_WAIT   = 3'd2,
        S_ACK    = 3'd3,
        S_ERR    = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
    localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
    localparam logic [3:0] REG_WAIT_C = 4'(REG_WAIT);
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;     // remaining wait states in count mode
    logic [7:0] tmo_q, tmo_d;               // saturating timeout counter
    logic       ready_mode_q, ready_mode_d; // WAIT ends on dev_ready, not on count
    logic       sampling_q, sampling_d;     // DECODE past its mapper-latency clock
    logic       map_enable_q, map_enable_d;
    logic       dtack_q, dtack_d;
    logic       berr_q, berr_d;
    logic       busy_q, busy_d;

    logic [7:0] cs_vec;
    logic       cs_any;
    logic       cs_multi;
    logic [7:0] tmo_inc;
    logic       tmo_hit;
    logic [3:0] load_wait;

    // Chip-select classification and timeout arithmetic shared by DECODE and WAIT
    always_comb begin
        cs_vec   = {csunmap, csram1, csram2, csrom, csio, csgfx, csctrl, cspgtbl};
        cs_any   = |cs_vec;
        // Clearing the lowest set bit leaves something only if two or more were set
        cs_multi = |(cs_vec & (cs_vec - 8'd1));
        tmo_inc  = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        tmo_hit  = (tmo_inc >= TIMEOUT_C);
        if (csrom) begin
            load_wait = ROM_WAIT_C;
        end else if (csctrl || cspgtbl) begin
            load_wait = REG_WAIT_C;
        end else begin
            load_wait = RAM_WAIT_C;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are registered
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        tmo_d        = tmo_q;
        ready_mode_d = ready_mode_q;
        sampling_d   = sampling_q;

        case (state_q)
            S_IDLE: begin
                if (cycle_req) begin
                    state_d      = S_DECODE;
                    tmo_d        = 8'd0;
                    wait_cnt_d   = 4'd0;
                    ready_mode_d = 1'b0;
                    sampling_d   = 1'b0;
                end
            end
            S_DECODE: begin
                if (!cycle_req) begin
                    state_d = S_DRAIN;
                end else if (!sampling_q) begin
                    // First DECODE clock only covers the mapper register latency
                    sampling_d = 1'b1;
                end else if (!cs_any) begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        state_d = S_ERR;
                    end
                end else if (cs_multi || csunmap) begin
                    state_d = S_ERR;
                end else if (csio || csgfx) begin
                    state_d      = S_WAIT;
                    ready_mode_d = 1'b1;
                    tmo_d        = 8'd0;
                end else if (load_wait == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    state_d      = S_WAIT;
                    ready_mode_d = 1'b0;
                    wait_cnt_d   = load_wait;
                end
            end
            S_WAIT: begin
                if (!cycle_req) begin
                    state_d = S_DRAIN;
                end else if (ready_mode_q) begin
                    if (dev_ready) begin
                        state_d = S_ACK;
                    end else begin
                        tmo_d = tmo_inc;
                        if (tmo_hit) begin
                            state_d = S_ERR;
                        end
                    end
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACK, S_ERR: begin
                if (!cycle_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Always pass through IDLE so a held cycle_req starts cleanly
                state_d      = S_IDLE;
                wait_cnt_d   = 4'd0;
                tmo_d        = 8'd0;
                ready_mode_d = 1'b0;
                sampling_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        map_enable_d = (state_d == S_DECODE) || (state_d == S_WAIT) ||
                       (state_d == S_ACK)    || (state_d == S_ERR);
        dtack_d      = (state_d == S_ACK);
        berr_d       = (state_d == S_ERR);
        busy_d       = (state_d != S_IDLE);
    end

    // State, counters and output registers; reset acts without a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 4'd0;
            tmo_q        <= 8'd0;
            ready_mode_q <= 1'b0;
            sampling_q   <= 1'b0;
            map_enable_q <= 1'b0;
            dtack_q      <= 1'b0;
            berr_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            tmo_q        <= tmo_d;
            ready_mode_q <= ready_mode_d;
            sampling_q   <= sampling_d;
            map_enable_q <= map_enable_d;
            dtack_q      <= dtack_d;
            berr_q       <= berr_d;
            busy_q       <= busy_d;
        end
    end

    assign map_enable = map_enable_q;
    assign dtack      = dtack_q;
    assign berr       = berr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl with default parameters. Outputs are
// compared as the vector {map_enable, dtack, berr, busy} one clock at a time,
// edge numbers counted from the edge after which cycle_req is raised.
module tb_bus_cycle_ctrl;

    logic clk;
    logic reset;
    logic cycle_req;
    logic csunmap, csram1, csram2, csrom, csio, csgfx, csctrl, cspgtbl;
    logic dev_ready;
    logic map_enable, dtack, berr, busy;
    logic [3:0] outs;

    int tests;
    int fails;

    localparam logic [3:0] O_IDLE  = 4'b0000;
    localparam logic [3:0] O_BUSY  = 4'b1001;  // DECODE or WAIT
    localparam logic [3:0] O_ACK   = 4'b1101;
    localparam logic [3:0] O_ERR   = 4'b1011;
    localparam logic [3:0] O_DRAIN = 4'b0001;

    bus_cycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cycle_req  (cycle_req),
        .csunmap    (csunmap),
        .csram1     (csram1),
        .csram2     (csram2),
        .csrom      (csrom),
        .csio       (csio),
        .csgfx      (csgfx),
        .csctrl     (csctrl),
        .cspgtbl    (cspgtbl),
        .dev_ready  (dev_ready),
        .map_enable (map_enable),
        .dtack      (dtack),
        .berr       (berr),
        .busy       (busy)
    );

    assign outs = {map_enable, dtack, berr, busy};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("[TB] %s: outs=%b expect=%b", tag, obs, exp);
    endtask

    // Advance n clocks, checking the same output pattern after each edge
    task automatic run(input string tag, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, outs, exp);
        end
    endtask

    task automatic clear_cs();
        {csunmap, csram1, csram2, csrom, csio, csgfx, csctrl, cspgtbl} = 8'h00;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        cycle_req = 1'b0;
        dev_ready = 1'b0;
        clear_cs();

        // Reset state
        #5;
        chk("reset_async", outs, O_IDLE);
        tick();
        tick();
        chk("reset_held", outs, O_IDLE);
        reset = 1'b0;
        run("idle_after_reset", 2, O_IDLE);

        // csram1, RAM_WAIT=2: sample e3, dtack e6
        csram1 = 1'b1;
        cycle_req = 1'b1;
        run("ram_decode_e1_e2", 2, O_BUSY);
        run("ram_wait_e3_e5", 3, O_BUSY);
        run("ram_dtack_e6", 1, O_ACK);
        run("ram_dtack_hold", 1, O_ACK);
        cycle_req = 1'b0;
        run("ram_drain", 1, O_DRAIN);
        // Request raised during DRAIN must still pass through IDLE
        cycle_req = 1'b1;
        run("drain_to_idle", 1, O_IDLE);
        run("idle_to_decode", 1, O_BUSY);
        // Abort in DECODE
        cycle_req = 1'b0;
        run("abort_decode_drain", 1, O_DRAIN);
        run("abort_decode_idle", 1, O_IDLE);
        clear_cs();

        // csunmap: berr two clocks after DECODE entry
        csunmap = 1'b1;
        cycle_req = 1'b1;
        run("unmap_decode", 2, O_BUSY);
        run("unmap_berr", 2, O_ERR);
        cycle_req = 1'b0;
        run("unmap_drain", 1, O_DRAIN);
        run("unmap_idle", 1, O_IDLE);
        clear_cs();

        // csio, dev_ready rises 10 clocks after sample
        csio = 1'b1;
        cycle_req = 1'b1;
        run("io_decode_sample", 3, O_BUSY);
        run("io_wait_ready", 10, O_BUSY);
        dev_ready = 1'b1;
        run("io_dtack", 1, O_ACK);
        dev_ready = 1'b0;
        cycle_req = 1'b0;
        run("io_drain", 1, O_DRAIN);
        run("io_idle", 1, O_IDLE);

        // csio, dev_ready never high: berr 64 clocks after sample (e67)
        cycle_req = 1'b1;
        run("io_tmo_decode_sample", 3, O_BUSY);
        run("io_tmo_wait", 63, O_BUSY);
        run("io_tmo_berr", 1, O_ERR);
        cycle_req = 1'b0;
        run("io_tmo_drain", 1, O_DRAIN);
        run("io_tmo_idle", 1, O_IDLE);
        clear_cs();

        // csrom with dev_ready held high: count mode ignores it, dtack at e8
        csrom = 1'b1;
        dev_ready = 1'b1;
        cycle_req = 1'b1;
        run("rom_wait", 7, O_BUSY);
        run("rom_dtack", 1, O_ACK);
        cycle_req = 1'b0;
        dev_ready = 1'b0;
        run("rom_drain", 1, O_DRAIN);
        run("rom_idle", 1, O_IDLE);

        // csrom aborted during WAIT: no dtack, no berr
        cycle_req = 1'b1;
        run("rom_abort_wait", 4, O_BUSY);
        cycle_req = 1'b0;
        run("rom_abort_drain", 1, O_DRAIN);
        run("rom_abort_idle", 2, O_IDLE);
        clear_cs();

        // Reset pulsed during ACK, then csctrl cycle with cycle_req still high
        csram2 = 1'b1;
        cycle_req = 1'b1;
        run("ram2_wait", 5, O_BUSY);
        run("ram2_dtack", 1, O_ACK);
        #3;
        reset = 1'b1;
        #1;
        chk("reset_in_ack", outs, O_IDLE);
        #2;
        reset = 1'b0;
        clear_cs();
        csctrl = 1'b1;
        run("ctrl_decode_wait", 4, O_BUSY);
        run("ctrl_dtack", 1, O_ACK);
        cycle_req = 1'b0;
        run("ctrl_drain", 1, O_DRAIN);
        run("ctrl_idle", 1, O_IDLE);
        clear_cs();

        // Two chip selects at sample: berr
        csram1 = 1'b1;
        csrom = 1'b1;
        cycle_req = 1'b1;
        run("multi_decode", 2, O_BUSY);
        run("multi_berr", 1, O_ERR);
        cycle_req = 1'b0;
        run("multi_drain", 1, O_DRAIN);
        run("multi_idle", 1, O_IDLE);
        clear_cs();

        // No chip select: counting starts at the first sample edge, berr at e66
        cycle_req = 1'b1;
        run("nocs_decode", 2, O_BUSY);
        run("nocs_hold", 63, O_BUSY);
        run("nocs_berr", 2, O_ERR);
        cycle_req = 1'b0;
        run("nocs_drain", 1, O_DRAIN);
        run("nocs_idle", 1, O_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
